pipelined_shifter: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/shift_level.sv | 33 +++
 rtl/pipelined_shifter.sv | 120 ++++++++++++
 tb/tb_pipelined_shifter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate op encodings and helpers.
// Used by the pipelined shifter and its per-level mux.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_ROL = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;

    // Encodings above OP_ROR are reserved.
    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return (op > OP_ROR);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log shifter: shift/rotate by DIST when enabled.
// Ports: i_data operand, i_op mode, i_en apply shift, i_msb SRA fill, o_data result.
module shift_level
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [OP_W-1:0]  i_op,
    input  logic             i_en,
    input  logic             i_msb,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            unique case (i_op)
                OP_SLL:  o_data = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
                OP_SRL:  o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
                // Fill uses the original operand MSB, not this level's input.
                OP_SRA:  o_data = {{DIST{i_msb}}, i_data[WIDTH-1:DIST]};
                OP_ROL:  o_data = {i_data[WIDTH-1-DIST:0],
                                   i_data[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  o_data = {i_data[DIST-1:0],
                                   i_data[WIDTH-1:DIST]};
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined log shifter: one register slice per shift level, valid/ready flow.
// Ports: clock/resetn, in_* request (valid/ready/data/shamt/op/tag),
// out_* result (valid/ready/data/tag/err).
module pipelined_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [OP_W-1:0]    in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam int LAST = SHAMT_W - 1;

    logic [SHAMT_W-1:0] r_valid;
    logic [SHAMT_W-1:0] r_err;
    logic [SHAMT_W-1:0] r_msb;
    logic [WIDTH-1:0]   r_data  [SHAMT_W];
    logic [SHAMT_W-1:0] r_shamt [SHAMT_W];
    logic [OP_W-1:0]    r_op    [SHAMT_W];
    logic [TAG_W-1:0]   r_tag   [SHAMT_W];

    logic [SHAMT_W-1:0] w_load;

    // A slice loads if it or any slice downstream is empty, or output drains.
    always_comb begin : load_chain
        logic w_run;
        w_load = '0;
        w_run  = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            w_run     = w_run | ~r_valid[k];
            w_load[k] = w_run;
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        logic               w_sv;
        logic [WIDTH-1:0]   w_sd;
        logic [SHAMT_W-1:0] w_ss;
        logic [OP_W-1:0]    w_so;
        logic [TAG_W-1:0]   w_st;
        logic               w_se;
        logic               w_sm;
        logic [WIDTH-1:0]   w_sh;

        if (k == 0) begin : g_src_in
            assign w_sv = in_valid;
            assign w_sd = in_data;
            assign w_ss = in_shamt;
            assign w_so = in_op;
            assign w_st = in_tag;
            assign w_se = is_reserved_op(in_op);
            assign w_sm = in_data[WIDTH-1];
        end else begin : g_src_reg
            assign w_sv = r_valid[k-1];
            assign w_sd = r_data[k-1];
            assign w_ss = r_shamt[k-1];
            assign w_so = r_op[k-1];
            assign w_st = r_tag[k-1];
            assign w_se = r_err[k-1];
            assign w_sm = r_msb[k-1];
        end

        // Shamt is consumed LSB first, so this level always looks at bit 0.
        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_lvl (
            .i_data (w_sd),
            .i_op   (w_so),
            .i_en   (w_ss[0] & ~w_se),
            .i_msb  (w_sm),
            .o_data (w_sh)
        );

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_op[k]    <= '0;
                r_tag[k]   <= '0;
                r_err[k]   <= 1'b0;
                r_msb[k]   <= 1'b0;
            end else if (w_load[k]) begin
                r_valid[k] <= w_sv;
                r_data[k]  <= w_sh;
                r_shamt[k] <= w_ss >> 1;
                r_op[k]    <= w_so;
                r_tag[k]   <= w_st;
                r_err[k]   <= w_se;
                r_msb[k]   <= w_sm;
            end
        end
    end

    // Final slice's control sideband has no consumer.
    logic w_unused;
    assign w_unused = ^{r_shamt[LAST], r_op[LAST], r_msb[LAST]};

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAST];
    assign out_data  = r_data[LAST];
    assign out_tag   = r_tag[LAST];
    assign out_err   = r_err[LAST];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed testbench for pipelined_shifter (WIDTH=32, TAG_W=5).
// Immediate assertions at each comparison point; one summary line.
module tb_pipelined_shifter;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    int errors = 0;
    int checks = 0;

    pipelined_shifter #(
        .WIDTH (32),
        .TAG_W (5)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one cycle; return at the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [4:0] tg);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
    endtask

    // Single request, out_ready high: checks exact 5-cycle latency.
    task automatic single(input string name, input logic [2:0] op,
                          input logic [31:0] d, input logic [4:0] sh,
                          input logic [4:0] tg, input logic [31:0] exp,
                          input logic experr);
        drive(op, d, sh, tg);
        chk({name, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk({name, "_early"}, out_valid, 0);
        tick();
        chk({name, "_vld"}, out_valid, 1);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_tag"}, out_tag, tg);
        chk({name, "_err"}, out_err, experr);
        tick();
    endtask

    logic [2:0]  s_op   [8];
    logic [31:0] s_data [8];
    logic [4:0]  s_sh   [8];
    logic [31:0] s_exp  [8];

    initial begin
        int nin;
        int nout;
        logic acc;

        s_op   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd0};
        s_data = '{32'h0000_00FF, 32'hF000_0000, 32'h8000_0000,
                   32'h1234_5678, 32'h1234_5678, 32'h7FFF_0000,
                   32'h8000_0000, 32'h0000_0001};
        s_sh   = '{5'd8, 5'd4, 5'd31, 5'd4, 5'd8, 5'd16, 5'd31, 5'd16};
        s_exp  = '{32'h0000_FF00, 32'h0F00_0000, 32'hFFFF_FFFF,
                   32'h2345_6781, 32'h7812_3456, 32'h0000_7FFF,
                   32'h4000_0000, 32'h0001_0000};

        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        resetn    = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_otag", out_tag, 0);
        chk("rst_oerr", out_err, 0);
        chk("rst_iready", in_ready, 1);
        tick();
        resetn = 1'b1;
        tick();

        single("sra", 3'd2, 32'h8000_00F0, 5'd4, 5'd3, 32'hF800_000F, 0);

        // ROL then ROR back to back.
        drive(3'd3, 32'h8000_0001, 5'd1, 5'd1);
        tick();
        drive(3'd4, 32'h0000_0001, 5'd1, 5'd2);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("rol_vld", out_valid, 1);
        chk("rol_data", out_data, 32'h0000_0003);
        chk("rol_tag", out_tag, 1);
        tick();
        chk("ror_vld", out_valid, 1);
        chk("ror_data", out_data, 32'h8000_0000);
        chk("ror_tag", out_tag, 2);
        tick();
        chk("b2b_empty", out_valid, 0);

        single("sll31", 3'd0, 32'hFFFF_FFFF, 5'd31, 5'd4, 32'h8000_0000, 0);
        single("srl31", 3'd1, 32'hFFFF_FFFF, 5'd31, 5'd5, 32'h0000_0001, 0);
        single("sh0_sll", 3'd0, 32'hA5C3_0F96, 5'd0, 5'd6, 32'hA5C3_0F96, 0);
        single("sh0_srl", 3'd1, 32'hA5C3_0F96, 5'd0, 5'd7, 32'hA5C3_0F96, 0);
        single("sh0_sra", 3'd2, 32'hA5C3_0F96, 5'd0, 5'd8, 32'hA5C3_0F96, 0);
        single("sh0_rol", 3'd3, 32'hA5C3_0F96, 5'd0, 5'd9, 32'hA5C3_0F96, 0);
        single("sh0_ror", 3'd4, 32'hA5C3_0F96, 5'd0, 5'd10, 32'hA5C3_0F96, 0);
        single("rsvd", 3'd6, 32'h1234_5678, 5'd7, 5'd17, 32'h1234_5678, 1);

        // Stall: five accepts fill the pipe, then backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(s_op[i], s_data[i], s_sh[i], 5'(i));
            chk("stall_acc_rdy", in_ready, 1);
            tick();
        end
        drive(s_op[5], s_data[5], s_sh[5], 5'd5);
        chk("stall_full_rdy", in_ready, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall_vld", out_valid, 1);
            chk("stall_data", out_data, s_exp[0]);
            chk("stall_tag", out_tag, 0);
            chk("stall_rdy", in_ready, 0);
        end

        out_ready = 1'b1;
        #1;
        nin  = 5;
        nout = 0;
        for (int c = 0; c < 40 && nout < 8; c++) begin
            if (nin < 8) drive(s_op[nin], s_data[nin], s_sh[nin], 5'(nin));
            else in_valid = 1'b0;
            acc = in_valid & in_ready;
            if (out_valid) begin
                chk("drain_data", out_data, s_exp[nout]);
                chk("drain_tag", out_tag, 32'(nout));
                chk("drain_err", out_err, 0);
                nout++;
            end
            tick();
            if (acc) nin++;
        end
        in_valid = 1'b0;
        chk("drain_count", nout, 8);
        tick();
        chk("drain_empty", out_valid, 0);

        // Reset while three requests are in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 32'h0000_0001, 5'(i + 1), 5'(20 + i));
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("pre_rst_vld", out_valid, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_tag", out_tag, 0);
        chk("mid_rst_rdy", in_ready, 1);
        @(negedge clock);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_idle", out_valid, 0);
        end
        single("post_rst", 3'd1, 32'h8000_0000, 5'd3, 5'd30, 32'h1000_0000, 0);
        chk("post_rst_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
